// File: rtl/tk1_spi_master.sv
`default_nettype none
// ============================================================================
// Module  : tk1_spi_master
// Brief   : Memory-mapped SPI mode-0 byte engine (MSB first) for the tk1 core.
// Revision: 1.0 - initial release
// ============================================================================
module tk1_spi_master #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        spi_ss,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] ADDR_EN   = 8'h80;
    localparam logic [7:0] ADDR_XFER = 8'h81;
    localparam logic [7:0] ADDR_DATA = 8'h82;
    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);

    state_t      state;
    logic [7:0]  tx_reg;
    logic [7:0]  rx_reg;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_ctr;
    logic [7:0]  div_ctr;
    logic        unused_wdata;

    assign unused_wdata = &{1'b0, write_data[31:8]};
    assign ready        = cs;

    always_comb begin
        read_data = 32'h0;
        if (cs) begin
            case (address)
                ADDR_EN:   read_data = {31'h0, ~spi_ss};
                ADDR_XFER: read_data = {31'h0, state == IDLE};
                ADDR_DATA: read_data = {24'h0, rx_reg};
                default:   read_data = 32'h0;
            endcase
        end
    end

    // Bus writes are only honoured in IDLE; MOSI is a register that tracks
    // tx_reg[7] outside a transfer so the first bit is set up early.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            spi_ss    <= 1'b1;
            spi_sck   <= 1'b0;
            spi_mosi  <= 1'b0;
            tx_reg    <= 8'h0;
            rx_reg    <= 8'h0;
            shift_reg <= 8'h0;
            bit_ctr   <= 3'd0;
            div_ctr   <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    spi_sck <= 1'b0;
                    if (cs && we) begin
                        case (address)
                            ADDR_EN: spi_ss <= ~write_data[0];
                            ADDR_DATA: begin
                                tx_reg   <= write_data[7:0];
                                spi_mosi <= write_data[7];
                            end
                            ADDR_XFER: begin
                                shift_reg <= tx_reg;
                                bit_ctr   <= 3'd0;
                                div_ctr   <= 8'd0;
                                state     <= LOW;
                            end
                            default: ;
                        endcase
                    end
                end
                LOW: begin
                    if (div_ctr == DIV_LAST) begin
                        div_ctr <= 8'd0;
                        spi_sck <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        div_ctr <= div_ctr + 8'd1;
                    end
                end
                HIGH: begin
                    if (div_ctr == DIV_LAST) begin
                        // Falling edge of SCK: capture MISO, present next bit.
                        shift_reg <= {shift_reg[6:0], spi_miso};
                        div_ctr   <= 8'd0;
                        spi_sck   <= 1'b0;
                        if (bit_ctr == 3'd7) begin
                            spi_mosi <= tx_reg[7];
                            state    <= DONE;
                        end else begin
                            spi_mosi <= shift_reg[6];
                            bit_ctr  <= bit_ctr + 3'd1;
                            state    <= LOW;
                        end
                    end else begin
                        div_ctr <= div_ctr + 8'd1;
                    end
                end
                DONE: begin
                    rx_reg <= shift_reg;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
